// File: rtl/reduce_pipe_flopped.sv
// Square, XOR-fold and 1-bit reduce of each accepted word, with valid/ready flow control.
// Define REDUCE_STATS_EN to add ones_count, a saturating count of transferred 1 results.
module reduce_pipe_flopped #(
  parameter int BITWIDTH       = 16,
  parameter int NUM_IN_STAGES  = 1,
  parameter int NUM_OUT_STAGES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic [1:0]          in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_result,
  output logic [1:0]          out_mode
`ifdef REDUCE_STATS_EN
  ,
  output logic [15:0]         ones_count
`endif
);
  localparam int STAGES = NUM_IN_STAGES + 2 + NUM_OUT_STAGES;
  localparam int F_S    = NUM_IN_STAGES + 1;

  typedef enum logic [1:0] {M_OR = 2'b00, M_AND = 2'b01, M_XOR = 2'b10, M_NOR = 2'b11} mode_e;

  logic [STAGES-1:0]                      vld_pipe_q;
  logic [STAGES-1:0][1:0]                 mode_q;
  logic [NUM_IN_STAGES-1:0][BITWIDTH-1:0] din_q;
  logic [2*BITWIDTH-1:0]                  op_w, sq_d, sq_q;
  logic [BITWIDTH-1:0]                    f_d, f_q;
  logic [NUM_OUT_STAGES-1:0]              res_q;
  logic                                   res_d, en;

  // One enable for the whole pipe: a stalled output freezes every stage.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign op_w = {{BITWIDTH{1'b0}}, din_q[NUM_IN_STAGES-1]};
  assign sq_d = op_w * op_w;
  assign f_d  = sq_q[BITWIDTH-1:0] ^ sq_q[2*BITWIDTH-1:BITWIDTH];

  always_comb begin
    res_d = 1'b0;
    case (mode_e'(mode_q[F_S]))
      M_OR:    res_d = |f_q;
      M_AND:   res_d = &f_q;
      M_XOR:   res_d = ^f_q;
      M_NOR:   res_d = ~|f_q;
      default: res_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      mode_q     <= '0;
      din_q      <= '0;
      sq_q       <= '0;
      f_q        <= '0;
      res_q      <= '0;
    end else if (en) begin
      // Bubbles enter with zeroed data/mode so idle stages stay quiet.
      vld_pipe_q <= {vld_pipe_q[STAGES-2:0], in_valid};
      mode_q     <= {mode_q[STAGES-2:0], (in_valid ? in_mode : 2'b00)};
      din_q[0]   <= in_valid ? in_data : '0;
      for (int i = 1; i < NUM_IN_STAGES; i++) din_q[i] <= din_q[i-1];
      sq_q       <= sq_d;
      f_q        <= f_d;
      res_q[0]   <= res_d;
      for (int k = 1; k < NUM_OUT_STAGES; k++) res_q[k] <= res_q[k-1];
    end
  end

  assign out_valid  = vld_pipe_q[STAGES-1];
  assign out_mode   = mode_q[STAGES-1];
  assign out_result = res_q[NUM_OUT_STAGES-1];

`ifdef REDUCE_STATS_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (out_valid && out_ready && out_result && (cnt_q != 16'hFFFF))
      cnt_q <= cnt_q + 16'd1;
  end

  assign ones_count = cnt_q;
`endif
endmodule

// File: tb/tb_reduce_pipe_flopped.sv
// Bench for reduce_pipe_flopped: directed table, stall/reset sequences and a random
// stream, all scored against a queue of results computed from square/fold/reduce arithmetic.
module tb_reduce_pipe_flopped;
  localparam int W = 16;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, out_result;
  logic [W-1:0] in_data;
  logic [1:0]   in_mode, out_mode;
`ifdef REDUCE_STATS_EN
  logic [15:0]  ones_count;
`endif

  always #5 clk = ~clk;

  reduce_pipe_flopped #(.BITWIDTH(W), .NUM_IN_STAGES(1), .NUM_OUT_STAGES(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_mode  (out_mode)
`ifdef REDUCE_STATS_EN
    ,
    .ones_count(ones_count)
`endif
  );

  typedef struct { logic [W-1:0] d; logic [1:0] m; logic r; } vec_t;
  typedef struct { logic r; logic [1:0] m; int cyc; } exp_t;

  vec_t        tbl [10];
  exp_t        q [$];
  int          errs = 0, checks = 0, cyc = 0, n_xfer = 0, tbl_idx = 0;
  bit          use_tbl = 0, lat_chk = 0;
  int unsigned ones_ref = 0;

  function automatic logic ref_reduce(logic [W-1:0] d, logic [1:0] m);
    longint unsigned sq;
    logic [W-1:0]    f;
    sq = d;
    sq = sq * sq;
    f  = sq[W-1:0] ^ sq[2*W-1:W];
    case (m)
      2'b00:   return |f;
      2'b01:   return &f;
      2'b10:   return ^f;
      default: return ~|f;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: sampled mid-cycle, so values are what the next rising edge captures.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_t e;
        e.m   = in_mode;
        e.cyc = cyc;
        if (use_tbl) begin
          e.r = tbl[tbl_idx].r;
          tbl_idx++;
        end else begin
          e.r = ref_reduce(in_data, in_mode);
        end
        q.push_back(e);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_out: got result %0b with no word pending (t=%0t)", out_result, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_result", out_result, e.r);
          chk("out_mode", out_mode, e.m);
          if (lat_chk) chk("latency", cyc - e.cyc, L);
          n_xfer++;
          if (e.r && ones_ref != 32'hFFFF) ones_ref++;
        end
      end
    end
  end

  initial forever begin
    @(posedge rst);
    q.delete();
    ones_ref = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and return just after the edge that accepts it.
  task automatic send(input logic [W-1:0] d, input logic [1:0] m);
    int n;
    bit acc;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          x0;
    logic        r0;
    logic [1:0]  m0;
    int          stale;

    tbl[0] = '{16'h0001, 2'b00, 1'b1};
    tbl[1] = '{16'h0000, 2'b00, 1'b0};
    tbl[2] = '{16'h0000, 2'b01, 1'b0};
    tbl[3] = '{16'h0000, 2'b10, 1'b0};
    tbl[4] = '{16'h0000, 2'b11, 1'b1};
    tbl[5] = '{16'hFFFF, 2'b01, 1'b1};
    tbl[6] = '{16'hFFFF, 2'b10, 1'b0};
    tbl[7] = '{16'h0003, 2'b10, 1'b0};
    tbl[8] = '{16'hFFFF, 2'b00, 1'b1};
    tbl[9] = '{16'h0002, 2'b11, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef REDUCE_STATS_EN
    chk("rst_ones_count", ones_count, 0);
`endif
    tick();
    rst = 1'b0;

    // Single word: presented in cycle 0, out_valid exactly in cycle L, for one cycle.
    lat_chk = 1; use_tbl = 1;
    in_valid = 1'b1; in_data = tbl[0].d; in_mode = tbl[0].m;
    for (int k = 1; k <= L; k++) begin
      tick();
      in_valid = 1'b0;
      chk($sformatf("single_valid_c%0d", k), out_valid, (k == L));
    end
    chk("single_result", out_result, 1);
    chk("single_mode", out_mode, 0);
    tick();
    chk("single_pulse_end", out_valid, 0);

    // Table vectors back-to-back; latency check implies consecutive outputs.
    for (int i = 1; i < 10; i++) send(tbl[i].d, tbl[i].m);
    drain();
    chk("tbl_consumed", tbl_idx, 10);
    use_tbl = 0; lat_chk = 0;

    // Six words with a 5-cycle output stall after the first result.
    x0 = n_xfer;
    fork
      begin
        for (int i = 0; i < 6; i++) send(W'($urandom), 2'($urandom));
      end
      begin
        int n;
        n = 0;
        do begin
          @(posedge clk);
          #2;
          n++;
        end while (!out_valid && n < 50);
        chk("stall_first_valid", out_valid, 1);
        out_ready = 1'b0;
        r0 = out_result;
        m0 = out_mode;
        repeat (5) begin
          @(posedge clk);
          #2;
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
          chk("stall_out_result", out_result, r0);
          chk("stall_out_mode", out_mode, m0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_xfer_count", n_xfer - x0, 6);
`ifdef REDUCE_STATS_EN
    chk("stall_ones_count", ones_count, ones_ref);
`endif

    // Reset with three words in flight: everything dropped at once.
    for (int i = 0; i < 3; i++) send(16'h0001, 2'b00);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_result", out_result, 0);
    chk("midrst_out_mode", out_mode, 0);
`ifdef REDUCE_STATS_EN
    chk("midrst_ones_count", ones_count, 0);
`endif
    tick();
    rst = 1'b0;
    stale = 0;
    repeat (10) begin
      tick();
      if (out_valid) stale++;
    end
    chk("no_stale_after_rst", stale, 0);
    lat_chk = 1;
    send(16'h0001, 2'b00);
    for (int k = 2; k <= L; k++) begin
      tick();
      chk($sformatf("postrst_valid_c%0d", k), out_valid, (k == L));
    end
    drain();
    lat_chk = 0;

    // Random stream with random gaps and backpressure.
    x0 = n_xfer;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       in_data = '0;
        1:       in_data = '1;
        default: in_data = W'($urandom);
      endcase
      in_mode   = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
    if (n_xfer - x0 < 100) chk("random_xfer_low", n_xfer - x0, 100);
`ifdef REDUCE_STATS_EN
    chk("random_ones_count", ones_count, ones_ref);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/reduce_pipe_flopped.md
Name: reduce_pipe_flopped

Overview:
- Parametrised successor to the fixed 16-bit flopped OR-reduce benchmark block.
- Generalised in width, input/output pipeline depth and reduction mode.
- Adds valid/ready flow control with backpressure and an asynchronous reset.
- Per accepted word: square it, XOR-fold the square to BITWIDTH bits, then reduce to one bit in the selected mode. Sits in the synthesis-benchmark input designs as a timing/area test vehicle.

Parameters:
- BITWIDTH, 16, input word width; legal values 2..64.
- NUM_IN_STAGES, 1, input register stages before the squarer; must be >= 1.
- NUM_OUT_STAGES, 1, register stages after the reduction; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data/in_mode valid
- in_ready  output  1  block can accept an input this cycle
- in_data  input  BITWIDTH  operand word
- in_mode  input  2  reduction mode: 00 OR, 01 AND, 10 XOR (parity), 11 NOR
- out_valid  output  1  out_result/out_mode valid
- out_ready  input  1  downstream accepts the result
- out_result  output  1  reduced bit
- out_mode  output  2  mode that produced out_result

Behaviour:
- Datapath per word:
  - sq = d*d, unsigned, full 2*BITWIDTH bits.
  - f = sq[BITWIDTH-1:0] ^ sq[2*BITWIDTH-1:BITWIDTH].
  - r = OR(f), AND(f), XOR(f) or ~OR(f), per the mode carried with the word.
- Pipeline, one register per step:
  - NUM_IN_STAGES input regs, then the sq reg, then the f reg.
  - The combinational reduce feeds NUM_OUT_STAGES output regs.
  - The last output reg drives out_result.
- Latency L = NUM_IN_STAGES + 2 + NUM_OUT_STAGES cycles from the accept edge to out_valid=1 when not stalled. Defaults give L=4.
- Every stage carries a valid bit and the 2-bit mode alongside its data.
- Global advance enable: en = !out_valid || out_ready. All stages (data, mode, valid) load only when en=1. in_ready = en (combinational).
- Input is accepted on a rising edge with in_valid && in_ready. When en=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Bubbles are not collapsed; throughput is one word per cycle when out_ready stays high.
- While out_valid && !out_ready: out_result and out_mode are held stable, no stage changes, and in_ready=0.
- Output transfer: out_valid && out_ready on a rising edge. The same edge advances the pipe, so a back-to-back result may appear on the next cycle.
- in_data and in_mode are ignored when in_valid=0 or in_ready=0.
- Reset (async assert, any time including mid-stream or mid-stall): all stage valids, out_valid, out_result, out_mode and all data/mode regs go to 0 immediately. In-flight words are dropped.
- First accept after reset is possible on the first rising edge after rst deasserts (in_ready=1 since out_valid=0).
- Width rules: no truncation before the fold. The product is exactly 2*BITWIDTH bits.

Optional Feature:
- Macro: REDUCE_STATS_EN.
- Defined:
  - Adds output port ones_count, 16 bits: counts output transfers with out_result=1.
  - Increments on the transfer edge only; stalled or held results are not counted.
  - Saturates at 16'hFFFF. Reset to 0 by rst.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then single word in_data=16'h0001, mode OR, out_ready=1 -> out_valid pulses exactly 4 cycles after accept, out_result=1, out_mode=00.
- Words 16'h0000 sent with modes OR, AND, XOR, NOR back-to-back -> results 0,0,0,1 on 4 consecutive cycles.
- 16'hFFFF in modes AND then XOR -> sq=32'hFFFE0001, f=16'hFFFF; results AND=1, XOR=0. Word 16'h0003, mode XOR -> f=16'h0009, result 0.
- Stream 6 words; hold out_ready=0 for 5 cycles after the first out_valid -> in_ready=0 throughout, out_result/out_mode stable; all 6 results delivered in order with no loss or duplication.
- Assert rst for 1 cycle with 3 words in flight -> out_valid=0 immediately; no stale result appears afterwards; a new word sent after reset returns after 4 cycles.
- With REDUCE_STATS_EN: 5 transfers with results 1,0,1,1 and a stalled 1 released after 3 hold cycles -> ones_count=4; preload near saturation -> holds at 16'hFFFF.
